fp_exp2_seq: RTL and testbench

FP_EXP2_SEQ -- requirements
Module: fp_exp2_seq

---
 rtl/fp_exp2_seq_if.sv | 15 +
 rtl/fp_exp2_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fp_exp2_seq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fp_exp2_seq_if.sv
// Handshake and result bus for the sequential 2^x unit.
interface fp_exp2_seq_if #(
    parameter int sig_width = 10,
    parameter int exp_width = 5
);
    logic                         start;
    logic [sig_width+exp_width:0] inst_a;
    logic                         busy;
    logic                         done;
    logic [sig_width+exp_width:0] z_inst;
    logic [7:0]                   status_inst;

    modport master (output start, inst_a, input busy, done, z_inst, status_inst);
    modport slave  (input start, inst_a, output busy, done, z_inst, status_inst);
endinterface

// File: rtl/fp_exp2_seq.sv
// Sequential floating-point 2^x: fixed-point split, shift-and-multiply by 2^(2^-k), round.
// Optional macro FP_EXP2_SEQ_RESTART_EN: a start while busy restarts with the new operand.
module fp_exp2_seq #(
    parameter int sig_width = 10,
    parameter int exp_width = 5
) (
    input logic         clk,
    input logic         rst_n,
    fp_exp2_seq_if.slave bus
);
    localparam int W    = sig_width + exp_width + 1;
    localparam int F    = sig_width + 2;
    localparam int FXW  = exp_width + F;
    localparam int AW   = F + 3;
    localparam int D    = F + 2 - sig_width;
    localparam int BIAS = (1 << (exp_width - 1)) - 1;
    localparam int CW   = $clog2(F);
    localparam int RN   = 2 ** CW;
    localparam int RP   = 60;
    localparam logic signed [exp_width+1:0] MAXE = (exp_width+2)'((1 << exp_width) - 1);

    typedef enum logic [2:0] {IDLE, DECOMP, ITER, NORM, DONE} state_t;
    typedef enum logic [2:0] {C_NUM, C_INF, C_ZERO, C_OVF, C_UNF} cls_t;

    // 2^(2^-k) via repeated high-precision integer square roots, rounded to F+2 fraction bits
    function automatic logic [RN-1:0][AW-1:0] rom_init();
        logic [127:0] v, x, r, t;
        logic [RN-1:0][AW-1:0] rom;
        rom = '0;
        v = 128'(2) << RP;
        for (int k = 0; k < F; k++) begin
            x = v << RP;
            r = '0;
            for (int i = 63; i >= 0; i--) begin
                t = r | (128'(1) << i);
                if (t * t <= x) r = t;
            end
            v = r;
            rom[k] = AW'((v + (128'(1) << (RP - F - 3))) >> (RP - F - 2));
        end
        return rom;
    endfunction

    localparam logic [RN-1:0][AW-1:0] ROM = rom_init();

    state_t state, nxt;
    logic   load;

    logic [W-1:0]           a_q;
    logic [exp_width-1:0]   n_q;
    logic [F-1:0]           f_sh;
    logic                   sticky_q, fnz_q;
    cls_t                   cls_q;
    logic [AW-1:0]          acc;
    logic [CW-1:0]          cnt;
    logic [W-1:0]           z_q;
    logic [7:0]             st_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        case (state)
            IDLE:    if (bus.start) begin nxt = DECOMP; load = 1'b1; end
            DECOMP:  nxt = ITER;
            ITER:    if (cnt == CW'(F - 1)) nxt = NORM;
            NORM:    nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
`ifdef FP_EXP2_SEQ_RESTART_EN
        if (bus.start && (state == DECOMP || state == ITER || state == NORM)) begin
            nxt  = DECOMP;
            load = 1'b1;
        end
`endif
    end

    // Operand to two's-complement fixed point; bits shifted out below 2^-F become sticky
    logic                 s;
    logic [exp_width-1:0] e;
    logic [sig_width:0]   sig;
    int                   sh;
    logic [FXW-1:0]       mag, fx;
    logic                 stk;
    cls_t                 cls;

    always_comb begin
        s   = a_q[W-1];
        e   = a_q[W-2:sig_width];
        sig = {1'b1, a_q[sig_width-1:0]};
        sh  = int'(e) - BIAS + F - sig_width;
        mag = '0;
        stk = 1'b0;
        cls = C_NUM;
        if (sh >= 0) begin
            mag = FXW'(sig) << sh;
        end else begin
            mag = FXW'(sig >> (-sh));
            stk = |(sig & ~({(sig_width+1){1'b1}} << (-sh)));
        end
        fx = s ? (FXW'(0) - mag - FXW'(stk)) : mag;
        if (e == '0) begin
            fx  = '0;
            stk = 1'b0;
        end else if (&e) begin
            cls = s ? C_ZERO : C_INF;
        end else if (int'(e) - BIAS >= exp_width - 1) begin
            cls = s ? C_UNF : C_OVF;
        end
    end

    logic [AW+F+1:0] prod;
    assign prod = {{(F+2){1'b0}}, acc} * {{(F+2){1'b0}}, ROM[cnt]};

    // Round-to-nearest-even of acc to sig_width fraction bits, then exponent/range handling
    logic [sig_width:0]              keep;
    logic                            gb, rb, rup, carry, inex;
    logic [sig_width+1:0]            sum;
    logic [sig_width-1:0]            mant;
    logic signed [exp_width+1:0]     be;
    logic [W-1:0]                    z_c;
    logic [7:0]                      st_c;

    always_comb begin
        keep  = acc[AW-1:D];
        gb    = acc[D-1];
        rb    = (|acc[D-2:0]) | sticky_q;
        rup   = gb & (rb | keep[0]);
        sum   = {1'b0, keep} + (sig_width+2)'(rup);
        carry = sum[sig_width+1];
        mant  = carry ? sum[sig_width:1] : sum[sig_width-1:0];
        inex  = sticky_q | (|acc[D-1:0]) | fnz_q;
        be    = $signed({{2{n_q[exp_width-1]}}, n_q}) + $signed((exp_width+2)'(BIAS))
              + $signed({{(exp_width+1){1'b0}}, carry});
        z_c   = '0;
        st_c  = 8'h00;
        case (cls_q)
            C_INF:  begin z_c = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}}; st_c = 8'h02; end
            C_ZERO: st_c = 8'h01;
            C_OVF:  begin z_c = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}}; st_c = 8'h32; end
            C_UNF:  st_c = 8'h29;
            default: begin
                if (be >= MAXE) begin
                    z_c  = {1'b0, {exp_width{1'b1}}, {sig_width{1'b0}}};
                    st_c = 8'h32;
                end else if (be[exp_width+1] || be == '0) begin
                    st_c = 8'h29;
                end else begin
                    z_c  = {1'b0, be[exp_width-1:0], mant};
                    st_c = {2'b00, inex, 5'b00000};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            n_q      <= '0;
            f_sh     <= '0;
            sticky_q <= 1'b0;
            fnz_q    <= 1'b0;
            cls_q    <= C_NUM;
            acc      <= '0;
            cnt      <= '0;
            z_q      <= '0;
            st_q     <= '0;
        end else begin
            if (load) a_q <= bus.inst_a;
            case (state)
                DECOMP: begin
                    n_q      <= fx[FXW-1:F];
                    f_sh     <= fx[F-1:0];
                    fnz_q    <= |fx[F-1:0];
                    sticky_q <= stk;
                    cls_q    <= cls;
                    acc      <= AW'(1) << (F + 2);
                    cnt      <= '0;
                end
                ITER: begin
                    cnt  <= cnt + CW'(1);
                    f_sh <= f_sh << 1;
                    if (f_sh[F-1]) begin
                        acc      <= prod[AW+F+1:F+2];
                        sticky_q <= sticky_q | (|prod[F+1:0]);
                    end
                end
                NORM: if (nxt == DONE) begin
                    z_q  <= z_c;
                    st_q <= st_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.z_inst      = z_q;
    assign bus.status_inst = st_q;
endmodule

// File: tb/tb_fp_exp2_seq.sv
// Directed bench for fp_exp2_seq: vector table plus busy-start, DONE-start and reset sequences.
module tb_fp_exp2_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

`ifdef FP_EXP2_SEQ_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    fp_exp2_seq_if #(.sig_width(10), .exp_width(5)) bus ();

    fp_exp2_seq #(.sig_width(10), .exp_width(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] z;
        logic [7:0]  st;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, output logic [15:0] z, output logic [7:0] st,
                          output int lat, output logic b1);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.inst_a = a;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.inst_a = 16'h5555;
        lat = 1;
        b1  = bus.busy;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        z  = bus.z_inst;
        st = bus.status_inst;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] z;
        logic [7:0]  st;
        int          lat, cyc, ndone, first;
        logic        b1;
        logic [15:0] zfirst;

        tbl[0]  = '{16'h4200, 16'h4800, 8'h00};
        tbl[1]  = '{16'hBC00, 16'h3800, 8'h00};
        tbl[2]  = '{16'h0000, 16'h3C00, 8'h00};
        tbl[3]  = '{16'h3800, 16'h3DA8, 8'h20};
        tbl[4]  = '{16'h4C00, 16'h7C00, 8'h32};
        tbl[5]  = '{16'hCC00, 16'h0000, 8'h29};
        tbl[6]  = '{16'h3C00, 16'h4000, 8'h00};
        tbl[7]  = '{16'h4000, 16'h4400, 8'h00};
        tbl[8]  = '{16'h7C00, 16'h7C00, 8'h02};
        tbl[9]  = '{16'hFC00, 16'h0000, 8'h01};
        tbl[10] = '{16'h7E00, 16'h7C00, 8'h02};
        tbl[11] = '{16'h0001, 16'h3C00, 8'h00};
        tbl[12] = '{16'h8000, 16'h3C00, 8'h00};
        tbl[13] = '{16'h4B80, 16'h7800, 8'h00};
        tbl[14] = '{16'hCB00, 16'h0400, 8'h00};
        tbl[15] = '{16'hCB80, 16'h0000, 8'h29};
        tbl[16] = '{16'h4BC0, 16'h79A8, 8'h20};
        tbl[17] = '{16'hB800, 16'h39A8, 8'h20};
        tbl[18] = '{16'h0400, 16'h3C00, 8'h20};

        bus.start  = 1'b0;
        bus.inst_a = 16'h0000;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_z", 32'(bus.z_inst), 32'd0);
        chk("rst_st", 32'(bus.status_inst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run_op(tbl[i].a, z, st, lat, b1);
            chk($sformatf("v%0d_z", i), 32'(z), 32'(tbl[i].z));
            chk($sformatf("v%0d_st", i), 32'(st), 32'(tbl[i].st));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'd15);
            chk($sformatf("v%0d_busy", i), 32'(b1), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(bus.done), 32'd0);
        end

        // Second start at cycle 5 of an operation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.inst_a = 16'h4200;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.inst_a = 16'h5555;
        cyc = 1; ndone = 0; first = 0; zfirst = '0;
        while (cyc < 45) begin
            if (bus.done === 1'b1) begin
                ndone++;
                if (first == 0) begin first = cyc; zfirst = bus.z_inst; end
            end
            if (cyc == 5) begin bus.start = 1'b1; bus.inst_a = 16'h3C00; end
            if (cyc == 6) begin bus.start = 1'b0; bus.inst_a = 16'h5555; end
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_ndone", 32'(ndone), 32'd1);
        chk("busy_start_cycle", 32'(first), RESTART ? 32'd20 : 32'd15);
        chk("busy_start_z", 32'(zfirst), RESTART ? 32'h4000 : 32'h4800);

        // Start during DONE is ignored; result holds
        run_op(16'h4200, z, st, lat, b1);
        bus.start  = 1'b1;
        bus.inst_a = 16'h3C00;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("done_start_busy", 32'(bus.busy), 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("done_start_ndone", 32'(ndone), 32'd0);
        chk("hold_z", 32'(bus.z_inst), 32'h4800);

        // Reset in the middle of an operation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.inst_a = 16'h3800;
        @(negedge clk);
        bus.start  = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_z", 32'(bus.z_inst), 32'd0);
        chk("mid_rst_st", 32'(bus.status_inst), 32'd0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        bus.start  = 1'b1;
        bus.inst_a = 16'h4000;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.inst_a = 16'h5555;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("post_rst_lat", 32'(lat), 32'd15);
        chk("post_rst_z", 32'(bus.z_inst), 32'h4400);
        chk("post_rst_st", 32'(bus.status_inst), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
